serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/fa_ha.sv | 14 +
 rtl/serial_adder.sv | 97 +++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration-time checks for the bit-serial adder.
// Imported by the adder top so the state encoding lives in one place.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/fa_ha.sv
// 1-bit full adder used as the arithmetic slice of the serial adder.
// Purely combinational; the caller registers the carry between bits.
module fa_ha (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit pair per clock, LSB first,
// carry held in a flop; registered sum/cout presented with a done strobe.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_width_chk
      $error("serial_adder: WIDTH out of range 2..32");
    end
  endgenerate

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  s_sh;
  logic              carry;
  logic [CNT_W-1:0]  cnt;
  logic              fa_s;
  logic              fa_cout;
  logic              accept;
  logic              last_bit;

  fa_ha u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // start is only honoured between operations; in RUN it is dropped.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= 1'b0;
        cnt   <= '0;
      end else if (state == RUN) begin
        s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= fa_cout;
        cnt   <= cnt + 1'b1;
        // Result registers move only here, so they hold across later RUNs.
        if (last_bit) begin
          sum  <= {fa_s, s_sh[WIDTH-1:1]};
          cout <= fa_cout;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a queue of expected {cout,sum} results.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Drive a one-cycle start pulse and record the expected result.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    a = '0;
    b = '0;
  endtask

  // Wait (bounded) for done, then compare against the scoreboard head.
  task automatic wait_done(input string tag, output int done_cyc);
    int n;
    logic [W:0] e;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, {24'd0, sum}, {24'd0, e[W-1:0]});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e[W]});
    end
  endtask

  task automatic count_dones(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int nb;
    int dc0, dc1;
    int ndone;
    logic [W-1:0] ta[3];
    logic [W-1:0] tb_[3];

    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);

    // Basic add with busy length and hold check
    start_op(8'h5A, 8'h3C);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    chk("basic_busy_len", nb, W);
    wait_done("basic", dc0);
    @(negedge clk);
    chk("basic_done_1cyc", {31'd0, done}, 32'd0);
    chk("basic_idle_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    chk("basic_hold_sum", {24'd0, sum}, 32'h96);
    chk("basic_hold_cout", {31'd0, cout}, 32'd0);

    // Carry boundaries
    ta[0] = 8'hFF; tb_[0] = 8'h01;
    ta[1] = 8'hFF; tb_[1] = 8'hFF;
    ta[2] = 8'h00; tb_[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb_[i]);
      wait_done($sformatf("carry%0d", i), dc0);
    end

    // start during RUN is ignored
    start_op(8'h12, 8'h34);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'hC3;
    b = 8'h77;
    @(negedge clk);
    start = 1'b0;
    a = '0;
    b = '0;
    wait_done("ignore", dc0);
    count_dones(15, ndone);
    chk("ignore_single_done", ndone, 0);
    chk("ignore_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    exp_q.push_back(model(8'h01, 8'h02));
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    exp_q.push_back(model(8'h80, 8'h80));
    wait_done("b2b_first", dc0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b_second", dc1);
    chk("b2b_spacing", dc1 - dc0, W + 1);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1;
    a = 8'h77;
    b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum", {24'd0, sum}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(15, ndone);
    chk("arst_no_done", ndone, 0);
    start_op(8'h10, 8'h20);
    wait_done("post_rst", dc0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
